// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder around one full adder, valid/ready handshakes
// Build option: define SERIAL_SUBTRACT_EN to add the sub input (a - b as a + ~b + 1).

module structuralFullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    logic g;
    logic t;

    assign p    = a ^ b;
    assign g    = a & b;
    assign t    = p & cin;
    assign s    = p ^ cin;
    assign cout = g | t;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_SUBTRACT_EN
    ,
    input  logic             sub
`endif
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH:0]   sum_cat;
    logic [WIDTH-1:0] b_load;
    logic             carry;
    logic             carry_load;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_SUBTRACT_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // cnt reaches WIDTH after the last bit; that final SHIFT cycle only settles into DONE
    assign last    = (cnt == CW'(WIDTH));
    assign accept  = in_valid && in_ready;
    assign sum_cat = {fa_s, sum_sr};

    structuralFullAdder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            SHIFT:   busy = 1'b1;
            DONE:    begin out_valid = 1'b1; busy = 1'b1; end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == SHIFT && !last) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_cat[WIDTH:1];
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
        end
    end

    assign sum  = sum_sr;
    assign cout = carry;
endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand/sum width in bits (legal range 1..32).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand set a/b/cin presented.
REQ-005 Port: in_ready  output  1  block accepts operands this cycle.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry into bit 0.
REQ-009 Port: out_valid  output  1  sum/cout valid.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: sum  output  WIDTH  registered result.
REQ-012 Port: cout  output  1  carry out of bit WIDTH-1.
REQ-013 Port: busy  output  1  high in SHIFT or DONE.

Function
REQ-014 Block SHALL add LSB-first, one bit per clock, through a single instance of the team's structuralFullAdder as the only arithmetic element.
REQ-015 States SHALL be IDLE, SHIFT, DONE; encoding free.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready SHALL capture a, b into shift registers, cin into carry flop, clear bit counter, go to SHIFT.
REQ-017 SHIFT: each cycle SHALL feed operand LSBs and carry flop to the full adder, shift sum bit into sum register MSB end (right shift), store adder carryout in carry flop, increment counter.
REQ-018 After exactly WIDTH SHIFT cycles SHALL go to DONE; sum holds full result, cout = final carry flop.
REQ-019 DONE: out_valid=1; on out_ready SHALL go to IDLE next edge; otherwise hold.
REQ-020 Latency: out_valid SHALL rise WIDTH+1 rising edges after the accepting edge.
REQ-021 in_ready SHALL be 0 in SHIFT and DONE; in_valid there SHALL be ignored, operands not captured; no same-cycle DONE->accept bypass.
REQ-022 sum and cout SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 out_ready outside DONE SHALL have no effect.
REQ-024 Result SHALL equal (a + b + cin) mod 2^(WIDTH+1) split as {cout, sum}; wrap-around beyond WIDTH bits discarded into cout only.
REQ-025 WIDTH=1 SHALL work: one SHIFT cycle, out_valid two edges after accept.
REQ-026 Clock period SHALL exceed the full-adder gate path (>=200 time units in simulation).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry flop=0, counter=0, regardless of clock.
REQ-028 Reset asserted in SHIFT or DONE SHALL abort the operation; no result delivered; first edge after deassertion behaves as IDLE.

Configuration
REQ-029 Macro SERIAL_SUBTRACT_EN SHALL control subtract support.
REQ-030 With SERIAL_SUBTRACT_EN defined: extra port sub  input  1, captured at accept; sub=1 SHALL compute a - b as a + ~b + 1 (cin ignored, carry flop loaded 1); cout=1 means no borrow.
REQ-031 Without SERIAL_SUBTRACT_EN: no sub port, add only, all other behaviour identical.

Verification (WIDTH=8, clk period 200)
REQ-032 a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, out_valid 9 edges after accept.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0, new in_valid with a=0x55 ignored; then out_ready=1 -> IDLE next edge.
REQ-035 rst_n pulsed low at 4th SHIFT cycle -> outputs all 0, in_ready=1 asynchronously; next op 0x03+0x04 -> sum=0x07.
REQ-036 SERIAL_SUBTRACT_EN build: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-037 Back-to-back: in_valid held high with out_ready=1 -> accepts every WIDTH+3 cycles, each result correct.
